video_in_monitor: RTL and testbench
===================================

Name: video_in_monitor

Overview:
Parametrised successor to the ad-hoc HDMI-input availability/stability counters in the verification top. Measures the incoming frame period (clk cycles between vsync rising edges) and active-line count (de rising edges per frame), declares the input present, locked/stable, or lost, and flags glitches once locked. Sits between the hdmi_in_* pins (already in the clk domain) and hdmi_in_reader/LED logic; gates capture on a stable source.

Parameters:
CNT_W, 24, width of frame-period counter and frame_period output
LINE_W, 12, width of line counter and frame_lines output
STABLE_FRAMES, 8, consecutive matching frames required to lock (>=1)
TOL, 2, allowed |period - reference| in clk cycles for a match
TIMEOUT_CYCLES, 2**22, cycles without vsync rising edge before signal declared lost (< 2**CNT_W)

Ports:
clk  in  1  video/pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
vs  in  1  vsync, active high, synchronous to clk
de  in  1  data-enable, active high, synchronous to clk
signal_present  out  1  high in ACQUIRE or LOCKED
stable  out  1  high in LOCKED only
glitch  out  1  one-cycle pulse on mismatch while LOCKED
frame_period  out  CNT_W  last matched period, clk cycles
frame_lines  out  LINE_W  last matched active-line count
frame_count  out  8  frames counted while LOCKED, wraps 255->0

Behaviour:
- Reset: all outputs 0, state NO_SIGNAL, all counters 0, ref_valid 0.
- Edge detect: vs_d, de_d registered; vs_rise = vs & ~vs_d; de_rise = de & ~de_d.
- period_cnt: on vs_rise loads 1; else increments, saturating at TIMEOUT_CYCLES. Measured period = period_cnt at vs_rise (rises at t and t+P give P).
- line_cnt: on vs_rise loads 0 (de_rise in the same cycle counts as 1); else +1 per de_rise, saturating at 2**LINE_W-1. Measured lines = line_cnt at vs_rise.
- match = ref_valid & |meas_period - ref_period| <= TOL & meas_lines == ref_lines. Difference computed at CNT_W+1 bits, no wrap.
- States:
  NO_SIGNAL: counters idle except edge regs; vs_rise -> ACQUIRE, ref_valid 0, match_cnt 0 (first edge only opens measurement).
  ACQUIRE: on vs_rise: ref_valid 0 -> store ref, ref_valid 1; match -> match_cnt+1, and if match_cnt+1 == STABLE_FRAMES -> LOCKED, load frame_period/frame_lines; mismatch -> ref <= measurement, match_cnt 0.
  LOCKED: on vs_rise: match -> frame_count+1, frame_period/frame_lines updated (ref unchanged); mismatch -> glitch=1 for that cycle, ACQUIRE, ref <= measurement, match_cnt 0, frame_count held.
- Timeout: period_cnt == TIMEOUT_CYCLES with no vs_rise in ACQUIRE or LOCKED -> NO_SIGNAL, ref_valid 0, match_cnt 0; frame_period/frame_lines/frame_count hold last values.
- Simultaneous vs_rise and timeout: vs_rise wins.
- Output latency: state-derived outputs change the cycle after the deciding vs_rise; glitch is registered, same cycle as the state change.
- rst mid-frame: everything back to reset values next cycle, no glitch.
- vs held high: single rise only; period keeps counting, timeout applies.

Optional Feature:
VIDEO_MON_GLITCH_CNT_EN: adds output glitch_count (16 bits), +1 per glitch pulse, saturating at 16'hFFFF, cleared only by rst. Without the macro the port and its counter are absent; all other behaviour identical.

Test Plan:
Defaults except STABLE_FRAMES=4, TIMEOUT_CYCLES=4096; frames of 1000 cycles, 10 de pulses -> stable rises one cycle after 6th vs rise; frame_period=1000, frame_lines=10, signal_present high from 1st rise.
Locked, one frame of 1002 then 999 cycles -> no glitch (within TOL=2), frame_count +2; one frame of 1003 -> glitch one cycle, stable low, relock after 4 further 1003-cycle frames.
Locked, one frame with 9 lines at 1000 cycles -> glitch, ACQUIRE, ref_lines=9.
Stop vs after lock -> signal_present and stable low exactly 4096 cycles after last rise; frame_period still 1000.
vs rise coincident with period_cnt==4096 -> no timeout, measured period 4096 mismatches -> glitch; rst asserted mid-frame -> all outputs 0 next cycle.
With VIDEO_MON_GLITCH_CNT_EN: 3 induced glitches -> glitch_count=3; compile without macro -> port absent, other results unchanged.

Source files
------------

// File: rtl/video_in_monitor.sv
// Video input monitor: measures vsync period and active lines per frame, tracks NO_SIGNAL/ACQUIRE/LOCKED, pulses glitch on a locked mismatch.
// Define VIDEO_MON_GLITCH_CNT_EN to add the saturating 16-bit glitch_count output.
module video_in_monitor #(
   parameter int CNT_W          = 24,
   parameter int LINE_W         = 12,
   parameter int STABLE_FRAMES  = 8,
   parameter int TOL            = 2,
   parameter int TIMEOUT_CYCLES = 2**22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vs,
   input  logic              de,
   output logic              signal_present,
   output logic              stable,
   output logic              glitch,
   output logic [CNT_W-1:0]  frame_period,
   output logic [LINE_W-1:0] frame_lines,
`ifdef VIDEO_MON_GLITCH_CNT_EN
   output logic [7:0]        frame_count,
   output logic [15:0]       glitch_count
`else
   output logic [7:0]        frame_count
`endif
);

   localparam int MC_W = $clog2(STABLE_FRAMES + 1);
   localparam logic [CNT_W-1:0]  TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [LINE_W-1:0] LINE_MAX = '1;
   localparam logic [CNT_W:0]    TOL_V    = (CNT_W+1)'(TOL);

   typedef enum logic [1:0] {NO_SIGNAL, ACQUIRE, LOCKED} state_t;

   state_t            state_q, state_d;
   logic              vs_d, de_d, vs_rise, de_rise;
   logic [CNT_W-1:0]  period_cnt, ref_period;
   logic [LINE_W-1:0] line_cnt, ref_lines;
   logic              ref_valid;
   logic [MC_W-1:0]   match_cnt;
   logic signed [CNT_W:0] diff;
   logic [CNT_W:0]    abs_diff;
   logic              match, timeout;
   logic              store_ref, clr_ref, inc_match, clr_match, load_frame, inc_fc, glitch_d;

   assign vs_rise  = vs & ~vs_d;
   assign de_rise  = de & ~de_d;
   assign diff     = $signed({1'b0, period_cnt}) - $signed({1'b0, ref_period});
   assign abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
   assign match    = ref_valid && (abs_diff <= TOL_V) && (line_cnt == ref_lines);
   assign timeout  = (period_cnt == TIMEOUT);

   assign signal_present = (state_q != NO_SIGNAL);
   assign stable         = (state_q == LOCKED);

   always_comb begin
      state_d    = state_q;
      store_ref  = 1'b0;
      clr_ref    = 1'b0;
      inc_match  = 1'b0;
      clr_match  = 1'b0;
      load_frame = 1'b0;
      inc_fc     = 1'b0;
      glitch_d   = 1'b0;
      case (state_q)
         NO_SIGNAL: begin
            if (vs_rise) begin
               state_d   = ACQUIRE;
               clr_ref   = 1'b1;
               clr_match = 1'b1;
            end
         end
         ACQUIRE: begin
            if (vs_rise) begin
               if (!ref_valid) begin
                  store_ref = 1'b1;
               end else if (match) begin
                  inc_match = 1'b1;
                  if (int'(match_cnt) + 1 == STABLE_FRAMES) begin
                     state_d    = LOCKED;
                     load_frame = 1'b1;
                  end
               end else begin
                  store_ref = 1'b1;
                  clr_match = 1'b1;
               end
            end else if (timeout) begin
               state_d   = NO_SIGNAL;
               clr_ref   = 1'b1;
               clr_match = 1'b1;
            end
         end
         LOCKED: begin
            if (vs_rise) begin
               if (match) begin
                  inc_fc     = 1'b1;
                  load_frame = 1'b1;
               end else begin
                  glitch_d  = 1'b1;
                  state_d   = ACQUIRE;
                  store_ref = 1'b1;
                  clr_match = 1'b1;
               end
            end else if (timeout) begin
               state_d   = NO_SIGNAL;
               clr_ref   = 1'b1;
               clr_match = 1'b1;
            end
         end
         default: state_d = NO_SIGNAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NO_SIGNAL;
         vs_d         <= 1'b0;
         de_d         <= 1'b0;
         period_cnt   <= '0;
         line_cnt     <= '0;
         ref_period   <= '0;
         ref_lines    <= '0;
         ref_valid    <= 1'b0;
         match_cnt    <= '0;
         frame_period <= '0;
         frame_lines  <= '0;
         frame_count  <= '0;
         glitch       <= 1'b0;
      end else begin
         state_q <= state_d;
         vs_d    <= vs;
         de_d    <= de;
         glitch  <= glitch_d;
         // Counters stay frozen in NO_SIGNAL; the first vsync edge reopens them.
         if (vs_rise) begin
            period_cnt <= CNT_W'(1);
            line_cnt   <= LINE_W'(de_rise);
         end else if (state_q != NO_SIGNAL) begin
            if (period_cnt != TIMEOUT)
               period_cnt <= period_cnt + CNT_W'(1);
            if (de_rise && line_cnt != LINE_MAX)
               line_cnt <= line_cnt + LINE_W'(1);
         end
         if (store_ref) begin
            ref_period <= period_cnt;
            ref_lines  <= line_cnt;
            ref_valid  <= 1'b1;
         end else if (clr_ref) begin
            ref_valid <= 1'b0;
         end
         if (clr_match)
            match_cnt <= '0;
         else if (inc_match)
            match_cnt <= match_cnt + MC_W'(1);
         if (load_frame) begin
            frame_period <= period_cnt;
            frame_lines  <= line_cnt;
         end
         if (inc_fc)
            frame_count <= frame_count + 8'd1;
      end
   end

`ifdef VIDEO_MON_GLITCH_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         glitch_count <= '0;
      else if (glitch_d && glitch_count != 16'hFFFF)
         glitch_count <= glitch_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_video_in_monitor.sv
// Randomised frame-level bench for video_in_monitor with an expectation queue and a decoupled monitor.
module tb_video_in_monitor;
   localparam int SF  = 4;
   localparam int TO  = 4096;
   localparam int TOL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1, vs = 1'b0, de = 1'b0;
   logic signal_present, stable, glitch;
   logic [23:0] frame_period;
   logic [11:0] frame_lines;
   logic [7:0]  frame_count;
`ifdef VIDEO_MON_GLITCH_CNT_EN
   logic [15:0] glitch_count;
`endif

   video_in_monitor #(.STABLE_FRAMES(SF), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .vs(vs), .de(de),
      .signal_present(signal_present), .stable(stable), .glitch(glitch),
      .frame_period(frame_period), .frame_lines(frame_lines),
`ifdef VIDEO_MON_GLITCH_CNT_EN
      .frame_count(frame_count), .glitch_count(glitch_count)
`else
      .frame_count(frame_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc; int present; int stbl; int gl; int fp; int fl; int fc;
   } exp_t;
   exp_t q[$];

   int total = 0, passed = 0, gl_seen = 0;
   bit done = 0;

   // Frame-level reference: mode 0 = no signal, 1 = acquiring, 2 = locked.
   int  m_mode, m_refv, m_refp, m_refl, m_mcnt, m_fp, m_fl, m_fc;
   int  m_gl_total = 0, m_gcnt = 0, last_c = 0, lines_acc = 0;
   bit  prev_vs = 0, prev_de = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act == exp_v) passed++;
      else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp_v);
   endtask

   task automatic push_rec(input int c, input int g);
      exp_t e;
      e.cyc = c; e.present = (m_mode != 0); e.stbl = (m_mode == 2); e.gl = g;
      e.fp = m_fp; e.fl = m_fl; e.fc = m_fc;
      q.push_back(e);
   endtask

   task automatic model_rise(input int c, input int lines);
      int p, g;
      bit mt;
      p = c - last_c;
      last_c = c;
      g = 0;
      mt = m_refv && ((p > m_refp ? p - m_refp : m_refp - p) <= TOL) && (lines == m_refl);
      if (m_mode == 0) begin
         m_mode = 1; m_refv = 0; m_mcnt = 0;
      end else if (m_mode == 1) begin
         if (!m_refv) begin
            m_refp = p; m_refl = lines; m_refv = 1;
         end else if (mt) begin
            m_mcnt++;
            if (m_mcnt == SF) begin m_mode = 2; m_fp = p; m_fl = lines; end
         end else begin
            m_refp = p; m_refl = lines; m_mcnt = 0;
         end
      end else begin
         if (mt) begin
            m_fc = (m_fc + 1) % 256; m_fp = p; m_fl = lines;
         end else begin
            g = 1; m_mode = 1; m_refp = p; m_refl = lines; m_mcnt = 0;
            m_gl_total++;
            if (m_gcnt < 16'hFFFF) m_gcnt++;
         end
      end
      push_rec(c, g);
   endtask

   // Apply one cycle of inputs; c is the cycle whose negedge shows the result.
   task automatic drive(input logic v, input logic d, input logic r);
      int c;
      bit rise, drise;
      c = cyc + 1;
      vs = v; de = d; rst = r;
      if (r) begin
         m_mode = 0; m_refv = 0; m_mcnt = 0; m_fp = 0; m_fl = 0; m_fc = 0; m_gcnt = 0;
         prev_vs = 0; prev_de = 0; lines_acc = 0;
         push_rec(c, 0);
      end else begin
         rise  = v && !prev_vs;
         drise = d && !prev_de;
         if (rise) begin
            model_rise(c, lines_acc);
            lines_acc = drise;
         end else begin
            lines_acc += drise;
            if (m_mode != 0 && c - last_c == TO - 1) push_rec(c, 0);
            if (m_mode != 0 && c - last_c == TO) begin
               m_mode = 0; m_refv = 0; m_mcnt = 0;
               push_rec(c, 0);
            end
         end
         prev_vs = v; prev_de = d;
      end
      @(posedge clk); #1;
   endtask

   task automatic frame(input int p, input int l);
      for (int i = 0; i < p; i++)
         drive(i < 3, (i >= 10) && (i < 10 + l*20) && (((i - 10) % 20) < 5), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!done) begin
         if (glitch === 1'b1) gl_seen++;
         while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_expectation", q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("signal_present", int'(signal_present), q[0].present);
            chk("stable",         int'(stable),         q[0].stbl);
            chk("glitch",         int'(glitch),         q[0].gl);
            chk("frame_period",   int'(frame_period),   q[0].fp);
            chk("frame_lines",    int'(frame_lines),    q[0].fl);
            chk("frame_count",    int'(frame_count),    q[0].fc);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
      idle(20);
      // Acquire and lock on 1000-cycle, 10-line frames.
      for (int i = 0; i < 8; i++) frame(1000, 10);
      // Within tolerance, then just outside it, then relock.
      frame(1002, 10); frame(999, 10); frame(1000, 10);
      for (int i = 0; i < 7; i++) frame(1003, 10);
      // Line-count mismatch while locked, then relock on 9 lines.
      for (int i = 0; i < 7; i++) frame(1003, 9);
      // Randomised frames around the reference.
      for (int i = 0; i < 20; i++) begin
         int p, l;
         p = ($urandom_range(0, 9) < 8) ? 1003 + $urandom_range(0, 2) - 1 : 1003 + $urandom_range(3, 6);
         l = ($urandom_range(0, 9) == 0) ? 10 : 9;
         frame(p, l);
      end
      // Source stops: timeout, then reacquire and lock.
      frame(4200, 10);
      for (int i = 0; i < 7; i++) frame(1000, 10);
      // Rise exactly at the timeout count wins and mismatches.
      frame(4096, 10);
      frame(4097, 10);
      for (int i = 0; i < 7; i++) frame(1000, 10);
      // Reset mid-frame.
      idle(400);
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) frame(1000, 10);
      idle(10);
      done = 1;
      chk("queue_drained", q.size(), 0);
      chk("glitch_pulses", gl_seen, m_gl_total);
`ifdef VIDEO_MON_GLITCH_CNT_EN
      chk("glitch_count", int'(glitch_count), m_gcnt);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
